// File: rtl/shot_controller.sv
// rtl/shot_controller.sv - ammo, muzzle-flash timing, hit/miss evaluation and timed reload
module shot_controller #(
  parameter int AMMO_MAX      = 3,
  parameter int FLASH_FRAMES  = 2,
  parameter int RELOAD_FRAMES = 30,
  parameter int HIT_RADIUS    = 16,
  parameter int COORD_W       = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fire,
  input  logic               reload,
  input  logic               frame_tick,
  input  logic [COORD_W-1:0] cross_x,
  input  logic [COORD_W-1:0] cross_y,
  input  logic [COORD_W-1:0] duck_x,
  input  logic [COORD_W-1:0] duck_y,
  input  logic               duck_alive,
  output logic [2:0]         ammo,
  output logic               shot_flash,
  output logic               hit,
  output logic               miss,
  output logic               reloading,
  output logic [7:0]         led
);

  localparam int CNT_MAX = (FLASH_FRAMES > RELOAD_FRAMES) ? FLASH_FRAMES : RELOAD_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0]       AMMO_FULL  = 3'(AMMO_MAX);
  localparam logic [CNT_W-1:0] FLASH_END  = CNT_W'(FLASH_FRAMES);
  localparam logic [CNT_W-1:0] RELOAD_END = CNT_W'(RELOAD_FRAMES);
  localparam logic [COORD_W:0] RADIUS     = (COORD_W + 1)'(HIT_RADIUS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FLASH  = 2'd1,
    S_RELOAD = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] frame_cnt, frame_cnt_n;
  logic [2:0]       ammo_n;
  logic             shot_flash_n, reloading_n, hit_n, miss_n;
  logic             fire_prev, reload_prev;
  logic             fire_edge, reload_edge;
  logic [COORD_W:0] dx, dy;
  logic             on_target;

  function automatic logic [7:0] led_map(input logic [2:0] a, input logic f, input logic r);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < AMMO_MAX; i++) begin
      v[i] = (a > 3'(i));
    end
    v[6] = f;
    v[7] = r;
    return v;
  endfunction

  assign fire_edge   = fire & ~fire_prev;
  assign reload_edge = reload & ~reload_prev;

  // Distances are widened by one bit so the subtraction can never wrap.
  assign dx = (cross_x >= duck_x) ? ({1'b0, cross_x} - {1'b0, duck_x})
                                  : ({1'b0, duck_x} - {1'b0, cross_x});
  assign dy = (cross_y >= duck_y) ? ({1'b0, cross_y} - {1'b0, duck_y})
                                  : ({1'b0, duck_y} - {1'b0, cross_y});
  assign on_target = duck_alive && (dx <= RADIUS) && (dy <= RADIUS);

  always_comb begin
    state_n      = state;
    frame_cnt_n  = frame_cnt;
    ammo_n       = ammo;
    shot_flash_n = shot_flash;
    reloading_n  = reloading;
    hit_n        = 1'b0;
    miss_n       = 1'b0;
    case (state)
      S_IDLE: begin
        // A shot takes priority over a simultaneous reload request.
        if (fire_edge && (ammo != 3'd0)) begin
          state_n      = S_FLASH;
          ammo_n       = ammo - 3'd1;
          shot_flash_n = 1'b1;
          frame_cnt_n  = '0;
          hit_n        = on_target;
          miss_n       = ~on_target;
        end else if (reload_edge && (ammo != AMMO_FULL)) begin
          state_n     = S_RELOAD;
          reloading_n = 1'b1;
          frame_cnt_n = '0;
        end
      end
      S_FLASH: begin
        if (frame_cnt == FLASH_END) begin
          state_n      = S_IDLE;
          shot_flash_n = 1'b0;
        end else if (frame_tick) begin
          frame_cnt_n = frame_cnt + CNT_W'(1);
        end
      end
      S_RELOAD: begin
        if (frame_cnt == RELOAD_END) begin
          state_n     = S_IDLE;
          reloading_n = 1'b0;
          ammo_n      = AMMO_FULL;
        end else if (frame_tick) begin
          frame_cnt_n = frame_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n      = S_IDLE;
        shot_flash_n = 1'b0;
        reloading_n  = 1'b0;
      end
    endcase
  end

  // Prev registers reset high so a button held through reset is not an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      frame_cnt   <= '0;
      ammo        <= AMMO_FULL;
      shot_flash  <= 1'b0;
      reloading   <= 1'b0;
      hit         <= 1'b0;
      miss        <= 1'b0;
      fire_prev   <= 1'b1;
      reload_prev <= 1'b1;
      led         <= led_map(AMMO_FULL, 1'b0, 1'b0);
    end else begin
      state       <= state_n;
      frame_cnt   <= frame_cnt_n;
      ammo        <= ammo_n;
      shot_flash  <= shot_flash_n;
      reloading   <= reloading_n;
      hit         <= hit_n;
      miss        <= miss_n;
      fire_prev   <= fire;
      reload_prev <= reload;
      led         <= led_map(ammo_n, shot_flash_n, reloading_n);
    end
  end

endmodule

// File: tb/tb_shot_controller.sv
// tb/tb_shot_controller.sv - model-checked directed bench for shot_controller
module tb_shot_controller;

  localparam int AMMO   = 3;
  localparam int FLASHN = 2;
  localparam int RELN   = 30;
  localparam int RAD    = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       fire = 1'b0, reload = 1'b0, frame_tick = 1'b0;
  logic [9:0] cross_x = 10'd100, cross_y = 10'd100, duck_x = 10'd0, duck_y = 10'd0;
  logic       duck_alive = 1'b0;
  logic [2:0] ammo;
  logic       shot_flash, hit, miss, reloading;
  logic [7:0] led;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  int m_ammo = AMMO;
  bit m_flash = 0, m_reload = 0, m_hit = 0, m_miss = 0;
  int m_ticks = 0;
  bit m_fire_prev = 1, m_reload_prev = 1;

  shot_controller #(
    .AMMO_MAX(AMMO), .FLASH_FRAMES(FLASHN), .RELOAD_FRAMES(RELN),
    .HIT_RADIUS(RAD), .COORD_W(10)
  ) dut (
    .clk(clk), .reset(reset), .fire(fire), .reload(reload), .frame_tick(frame_tick),
    .cross_x(cross_x), .cross_y(cross_y), .duck_x(duck_x), .duck_y(duck_y),
    .duck_alive(duck_alive), .ammo(ammo), .shot_flash(shot_flash), .hit(hit),
    .miss(miss), .reloading(reloading), .led(led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_led();
    return 8'(((1 << m_ammo) - 1) | (int'(m_flash) << 6) | (int'(m_reload) << 7));
  endfunction

  task automatic m_reset_vals();
    m_ammo = AMMO; m_flash = 0; m_reload = 0; m_hit = 0; m_miss = 0;
    m_ticks = 0; m_fire_prev = 1; m_reload_prev = 1;
  endtask

  always @(negedge reset) m_reset_vals();

  // Model: what the outputs must be after each clock edge.
  always @(posedge clk) begin
    if (!reset) begin
      m_reset_vals();
    end else begin
      bit fe, re;
      int ax, ay;
      fe = fire && !m_fire_prev;
      re = reload && !m_reload_prev;
      m_hit = 0;
      m_miss = 0;
      if (m_flash) begin
        if (m_ticks == FLASHN) m_flash = 0;
        else if (frame_tick) m_ticks++;
      end else if (m_reload) begin
        if (m_ticks == RELN) begin
          m_reload = 0;
          m_ammo = AMMO;
        end else if (frame_tick) m_ticks++;
      end else if (fe && m_ammo > 0) begin
        m_ammo--;
        m_flash = 1;
        m_ticks = 0;
        ax = int'(cross_x) - int'(duck_x); if (ax < 0) ax = -ax;
        ay = int'(cross_y) - int'(duck_y); if (ay < 0) ay = -ay;
        m_hit = duck_alive && ax <= RAD && ay <= RAD;
        m_miss = !m_hit;
      end else if (re && m_ammo < AMMO) begin
        m_reload = 1;
        m_ticks = 0;
      end
      m_fire_prev = fire;
      m_reload_prev = reload;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ammo", 32'(ammo), 32'(m_ammo));
      chk("shot_flash", 32'(shot_flash), 32'(m_flash));
      chk("hit", 32'(hit), 32'(m_hit));
      chk("miss", 32'(miss), 32'(m_miss));
      chk("reloading", 32'(reloading), 32'(m_reload));
      chk("led", 32'(led), 32'(m_led()));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse_fire();
    fire = 1'b1; cyc(1); fire = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1; cyc(1); reload = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      cyc(2);
      frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
    end
  endtask

  // Literal expectation applied to both the DUT and the model.
  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] mdl,
                     input logic [31:0] exp);
    chk({name, "_dut"}, act, exp);
    chk({name, "_model"}, mdl, exp);
  endtask

  task automatic place(input int cx, input int cy, input int dx, input int dy, input bit al);
    cross_x = 10'(cx); cross_y = 10'(cy); duck_x = 10'(dx); duck_y = 10'(dy); duck_alive = al;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(3);
    chk_en = 1;
    lit("rst_ammo", 32'(ammo), 32'(m_ammo), 32'd3);
    lit("rst_led", 32'(led), 32'(m_led()), 32'h07);
    lit("rst_flash", 32'(shot_flash), 32'(m_flash), 32'd0);
    lit("rst_reloading", 32'(reloading), 32'(m_reload), 32'd0);
    lit("rst_hitmiss", 32'({hit, miss}), 32'({m_hit, m_miss}), 32'd0);

    // Fire held through reset release gives no shot.
    fire = 1'b1; cyc(1);
    reset = 1'b1; cyc(4);
    lit("held_fire_ammo", 32'(ammo), 32'(m_ammo), 32'd3);
    lit("held_fire_flash", 32'(shot_flash), 32'(m_flash), 32'd0);
    fire = 1'b0; cyc(2);

    // Hit inside radius.
    place(100, 100, 110, 90, 1);
    pulse_fire();
    lit("hit_pulse", 32'({hit, miss}), 32'({m_hit, m_miss}), 32'b10);
    lit("hit_ammo", 32'(ammo), 32'(m_ammo), 32'd2);
    lit("hit_led", 32'(led), 32'(m_led()), 32'h43);
    cyc(1);
    lit("hit_one_cycle", 32'(hit), 32'(m_hit), 32'd0);
    frames(1); cyc(2);
    lit("flash_after_1", 32'(shot_flash), 32'(m_flash), 32'd1);
    frames(1); cyc(3);
    lit("flash_after_2", 32'(shot_flash), 32'(m_flash), 32'd0);

    // Distance 17 misses; dead duck misses.
    place(100, 100, 117, 100, 1);
    pulse_fire();
    lit("miss17", 32'({hit, miss}), 32'({m_hit, m_miss}), 32'b01);
    lit("miss17_ammo", 32'(ammo), 32'(m_ammo), 32'd1);
    frames(2); cyc(3);
    place(100, 100, 110, 90, 0);
    pulse_fire();
    lit("miss_dead", 32'({hit, miss}), 32'({m_hit, m_miss}), 32'b01);
    frames(2); cyc(3);
    lit("empty_ammo", 32'(ammo), 32'(m_ammo), 32'd0);
    pulse_fire();
    lit("empty_fire", 32'({hit, miss, shot_flash}), 32'({m_hit, m_miss, m_flash}), 32'd0);
    cyc(2);

    // Reload from empty; fire ignored during reload.
    pulse_reload();
    lit("reloading", 32'(reloading), 32'(m_reload), 32'd1);
    lit("reload_led", 32'(led), 32'(m_led()), 32'h80);
    cyc(1);
    pulse_fire();
    lit("fire_in_reload", 32'(ammo), 32'(m_ammo), 32'd0);
    frames(29); cyc(2);
    lit("reload_29", 32'(reloading), 32'(m_reload), 32'd1);
    frames(1); cyc(3);
    lit("reload_done_ammo", 32'(ammo), 32'(m_ammo), 32'd3);
    lit("reload_done_led", 32'(led), 32'(m_led()), 32'h07);
    pulse_reload(); cyc(1);
    lit("reload_full_ignored", 32'(reloading), 32'(m_reload), 32'd0);

    // Exactly on the radius boundary is a hit.
    place(100, 100, 116, 84, 1);
    pulse_fire();
    lit("edge16_hit", 32'({hit, miss}), 32'({m_hit, m_miss}), 32'b10);
    frames(2); cyc(3);

    // Held fire fires once.
    fire = 1'b1;
    for (int k = 0; k < 20; k++) frames(1);
    fire = 1'b0; cyc(2);
    lit("held_one_shot", 32'(ammo), 32'(m_ammo), 32'd1);

    // Simultaneous fire and reload at ammo 1: shot wins.
    fire = 1'b1; reload = 1'b1; cyc(1); fire = 1'b0; reload = 1'b0;
    lit("both_ammo", 32'(ammo), 32'(m_ammo), 32'd0);
    lit("both_state", 32'({shot_flash, reloading}), 32'({m_flash, m_reload}), 32'b10);
    frames(2); cyc(3);
    lit("both_no_reload", 32'(reloading), 32'(m_reload), 32'd0);

    // Asynchronous reset mid-reload.
    pulse_reload();
    frames(10);
    reset = 1'b0; #1;
    lit("async_ammo", 32'(ammo), 32'(m_ammo), 32'd3);
    lit("async_reloading", 32'(reloading), 32'(m_reload), 32'd0);
    lit("async_led", 32'(led), 32'(m_led()), 32'h07);
    cyc(2);
    reset = 1'b1; cyc(4);
    lit("post_reset_ammo", 32'(ammo), 32'(m_ammo), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
